// File: rtl/multi_timestamp_if.sv
// Output stream of the multi-channel timestamp unit.
// Each FIFO head entry carries a timestamp and the channel index it
// belongs to, handed over with a valid/ready handshake.
//   out_ts    : timestamp at FIFO head
//   out_ch    : channel index at FIFO head
//   out_valid : FIFO holds at least one entry
//   out_ready : consumer accepts the head entry this cycle
// The master modport is the producer side; the slave modport is the consumer side.
interface multi_timestamp_if #(
    parameter int N_CH = 4,
    parameter int TS_W = 32
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [TS_W-1:0] out_ts;
    logic [CH_W-1:0] out_ch;
    logic            out_valid;
    logic            out_ready;

    modport master (output out_ts, output out_ch, output out_valid, input out_ready);
    modport slave  (input out_ts, input out_ch, input out_valid, output out_ready);
endinterface

// File: rtl/multi_timestamp.sv
// Multi-channel event timestamper.
// A prescaled tick counter is sampled on the rising edge of each detect
// channel.  Each channel enforces a holdoff measured in ticks, parks the
// captured value in a one-entry pending slot, and a fixed-priority arbiter
// (lowest channel first) moves pending entries into a shared output FIFO.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   detect     : per-channel event levels
//   fifo_out   : FIFO head stream {out_ts, out_ch, out_valid, out_ready}
//   fifo_level : current FIFO occupancy
//   overflow   : sticky per-channel lost-event flags
//   ovf_clr    : clears all overflow flags (a same-cycle set takes priority)
//   timer_now  : live tick counter
module multi_timestamp #(
    parameter int N_CH     = 4,
    parameter int TS_W     = 32,
    parameter int PRESCALE = 800,
    parameter int DEPTH    = 8,
    parameter int HOLDOFF  = 6250
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          detect,
    multi_timestamp_if.master        fifo_out,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [N_CH-1:0]          overflow,
    input  logic                     ovf_clr,
    output logic [TS_W-1:0]          timer_now
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;

    logic [PS_W-1:0] prescale_cnt;
    logic [TS_W-1:0] timer;
    logic            tick;

    logic [N_CH-1:0] detect_q;
    logic [N_CH-1:0] armed;
    logic [N_CH-1:0] hist;
    logic [N_CH-1:0] accept;
    logic [TS_W-1:0] last_ts [N_CH];
    logic [N_CH-1:0] pend_valid;
    logic [TS_W-1:0] pend_ts [N_CH];

    logic [TS_W-1:0] mem_ts [DEPTH];
    logic [CH_W-1:0] mem_ch [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    logic            found;
    logic [CH_W-1:0] sel;
    logic            push;
    logic            pop;

    assign tick = (prescale_cnt == PS_W'(PRESCALE - 1));

    // An edge counts only once the channel has been seen low since reset,
    // so a level held high through reset does not fire.  The holdoff test
    // uses modular subtraction so it stays correct across timer wrap.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            accept[i] = detect[i] & ~detect_q[i] & armed[i] &
                        (~hist[i] | ((timer - last_ts[i]) >= TS_W'(HOLDOFF)));
        end
    end

    // Descending scan: the last hit, i.e. the lowest index, wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pend_valid[i]) begin
                found = 1'b1;
                sel   = CH_W'(i);
            end
        end
    end

    // A full FIFO refuses a push even when it is popped in the same cycle.
    assign push = found && (fifo_level < LW'(DEPTH));
    assign pop  = fifo_out.out_valid && fifo_out.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_cnt <= '0;
            timer        <= '0;
            detect_q     <= '0;
            armed        <= ~detect;
            hist         <= '0;
            pend_valid   <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            overflow     <= '0;
            for (int i = 0; i < N_CH; i++) begin
                last_ts[i] <= '0;
                pend_ts[i] <= '0;
            end
        end else begin
            if (tick) begin
                prescale_cnt <= '0;
                timer        <= timer + TS_W'(1);
            end else begin
                prescale_cnt <= prescale_cnt + PS_W'(1);
            end

            detect_q <= detect;
            armed    <= armed | ~detect;

            // A pending slot stays busy through the cycle it is pushed, so an
            // accepted event that finds it busy is lost and flagged instead.
            for (int i = 0; i < N_CH; i++) begin
                if (accept[i] && !pend_valid[i]) begin
                    pend_valid[i] <= 1'b1;
                    pend_ts[i]    <= timer;
                    last_ts[i]    <= timer;
                    hist[i]       <= 1'b1;
                end
            end
            if (push) begin
                pend_valid[sel] <= 1'b0;
                wr_ptr          <= wr_ptr + AW'(1);
            end

            overflow <= (overflow & ~{N_CH{ovf_clr}}) | (accept & pend_valid);

            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_ts[wr_ptr] <= pend_ts[sel];
            mem_ch[wr_ptr] <= sel;
        end
    end

    assign fifo_out.out_ts    = mem_ts[rd_ptr];
    assign fifo_out.out_ch    = mem_ch[rd_ptr];
    assign fifo_out.out_valid = (fifo_level != '0);
    assign timer_now          = timer;
endmodule

// File: tb/tb_multi_timestamp.sv
module tb_multi_timestamp;
    localparam int A_PS    = 4;
    localparam int A_DEPTH = 4;
    localparam int A_HO    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_clr;
    logic [3:0]  a_det;
    logic [2:0]  a_level;
    logic [3:0]  a_ovf;
    logic [7:0]  a_timer;

    logic        b_rst, b_clr;
    logic [1:0]  b_det;
    logic [1:0]  b_level;
    logic [1:0]  b_ovf;
    logic [15:0] b_timer;

    multi_timestamp_if #(.N_CH(4), .TS_W(8))  a_if ();
    multi_timestamp_if #(.N_CH(2), .TS_W(16)) b_if ();

    multi_timestamp #(.N_CH(4), .TS_W(8), .PRESCALE(A_PS), .DEPTH(A_DEPTH), .HOLDOFF(A_HO)) dut_a (
        .clk(clk), .rst(a_rst), .detect(a_det), .fifo_out(a_if), .fifo_level(a_level),
        .overflow(a_ovf), .ovf_clr(a_clr), .timer_now(a_timer));

    multi_timestamp #(.N_CH(2), .TS_W(16), .PRESCALE(2), .DEPTH(2), .HOLDOFF(0)) dut_b (
        .clk(clk), .rst(b_rst), .detect(b_det), .fifo_out(b_if), .fifo_level(b_level),
        .overflow(b_ovf), .ovf_clr(b_clr), .timer_now(b_timer));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of instance A ----------------
    int  acyc = 0;
    bit  m_started = 0;
    int  m_last [4];
    bit  m_hist [4];
    bit  m_pv   [4];
    int  m_pts  [4];
    bit  m_prev [4];
    bit  m_seen [4];
    bit  [3:0] m_ovf;
    int  q_ts [$];
    int  q_ch [$];

    function automatic int a_tick(input int c);
        return (c / A_PS) % 256;
    endfunction

    always @(posedge clk) begin : a_model
        int t, sel;
        bit do_push, do_pop;
        bit [3:0] set_v, load_v;
        if (a_rst) begin
            acyc  = 0;
            m_ovf = '0;
            q_ts.delete();
            q_ch.delete();
            for (int i = 0; i < 4; i++) begin
                m_pv[i] = 0; m_hist[i] = 0; m_last[i] = 0; m_pts[i] = 0;
                m_prev[i] = 0; m_seen[i] = !a_det[i];
            end
            m_started = 1;
        end else begin
            t = a_tick(acyc);
            do_push = 0; sel = 0;
            if (q_ts.size() < A_DEPTH)
                for (int i = 3; i >= 0; i--)
                    if (m_pv[i]) begin do_push = 1; sel = i; end
            do_pop = (q_ts.size() > 0) && a_if.out_ready;
            set_v = '0; load_v = '0;
            for (int i = 0; i < 4; i++) begin
                if (a_det[i] && !m_prev[i] && m_seen[i] &&
                    (!m_hist[i] || ((t - m_last[i] + 256) % 256) >= A_HO)) begin
                    if (m_pv[i]) set_v[i] = 1; else load_v[i] = 1;
                end
            end
            if (do_pop) begin
                void'(q_ts.pop_front());
                void'(q_ch.pop_front());
            end
            if (do_push) begin
                q_ts.push_back(m_pts[sel]);
                q_ch.push_back(sel);
                m_pv[sel] = 0;
            end
            for (int i = 0; i < 4; i++) begin
                if (load_v[i]) begin
                    m_pv[i] = 1; m_pts[i] = t; m_last[i] = t; m_hist[i] = 1;
                end
                m_prev[i] = a_det[i];
                if (!a_det[i]) m_seen[i] = 1;
            end
            m_ovf = (m_ovf & ~{4{a_clr}}) | set_v;
            acyc++;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("a_valid", a_if.out_valid, q_ts.size() > 0);
            chk("a_level", a_level, q_ts.size());
            chk("a_ovf", a_ovf, m_ovf);
            chk("a_timer", a_timer, a_tick(acyc));
            if (q_ts.size() > 0) begin
                chk("a_head_ts", a_if.out_ts, q_ts[0]);
                chk("a_head_ch", a_if.out_ch, q_ch[0]);
            end
        end
    end

    // ---------------- instance B cycle counter ----------------
    int bcyc = 0;
    always @(posedge clk) begin
        if (b_rst) bcyc = 0;
        else bcyc++;
    end

    task automatic wait_a(input int n);
        int k = 0;
        while (acyc < n && k < 4000) begin
            @(negedge clk);
            k++;
        end
        if (acyc != n) begin
            total++; bad++;
            $display("FAIL a_wait reached=%0d wanted=%0d", acyc, n);
        end
    endtask

    task automatic wait_b(input int n);
        int k = 0;
        while (bcyc < n && k < 4000) begin
            @(negedge clk);
            k++;
        end
        if (bcyc != n) begin
            total++; bad++;
            $display("FAIL b_wait reached=%0d wanted=%0d", bcyc, n);
        end
    endtask

    task automatic a_reset();
        @(negedge clk);
        a_rst = 1'b1;
        repeat (2) @(negedge clk);
        a_rst = 1'b0;
    endtask

    task automatic run_a();
        a_rst = 1'b1; a_clr = 1'b0; a_det = '0; a_if.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("a_rst_valid", a_if.out_valid, 0);
        chk("a_rst_level", a_level, 0);
        chk("a_rst_ovf", a_ovf, 0);
        chk("a_rst_timer", a_timer, 0);
        a_rst = 1'b0;

        // single held-high edge on ch2
        wait_a(41);  a_det[2] = 1'b1;
        wait_a(42);  chk("a_lat_not_yet", a_if.out_valid, 0);
        wait_a(43);  chk("a_lat_valid", a_if.out_valid, 1);
                     chk("a_lat_ts", a_if.out_ts, 10);
                     chk("a_lat_ch", a_if.out_ch, 2);
                     chk("a_lat_level", a_level, 1);
        wait_a(60);  a_if.out_ready = 1'b1;
        wait_a(61);  a_if.out_ready = 1'b0;
        wait_a(100); chk("a_held_once", a_level, 0);
        wait_a(141); a_det[2] = 1'b0;

        // simultaneous edges: lower channel first
        a_if.out_ready = 1'b1;
        wait_a(160); a_det[0] = 1'b1; a_det[3] = 1'b1;
        wait_a(162); chk("a_prio_first_ch", a_if.out_ch, 0);
                     chk("a_prio_first_ts", a_if.out_ts, 40);
        wait_a(163); chk("a_prio_second_ch", a_if.out_ch, 3);
                     chk("a_prio_second_ts", a_if.out_ts, 40);
        wait_a(164); chk("a_prio_empty", a_if.out_valid, 0);
        wait_a(170); a_det = '0;

        // holdoff on ch1: ticks 10, 13 (rejected), 15
        a_reset();
        wait_a(40);  a_det[1] = 1'b1;
        wait_a(42);  chk("a_ho_first_ts", a_if.out_ts, 10);
                     chk("a_ho_first_ch", a_if.out_ch, 1);
        wait_a(44);  a_det[1] = 1'b0;
        wait_a(52);  a_det[1] = 1'b1;
        wait_a(54);  chk("a_ho_reject", a_if.out_valid, 0);
        wait_a(56);  a_det[1] = 1'b0;
        wait_a(60);  a_det[1] = 1'b1;
        wait_a(62);  chk("a_ho_third_valid", a_if.out_valid, 1);
                     chk("a_ho_third_ts", a_if.out_ts, 15);
        wait_a(64);  a_det[1] = 1'b0;
                     chk("a_ho_no_ovf", a_ovf[1], 0);

        // holdoff across timer wrap on ch3
        wait_a(1016); a_det[3] = 1'b1;
        wait_a(1018); chk("a_wrap_ts254", a_if.out_ts, 254);
                      chk("a_wrap_ch", a_if.out_ch, 3);
        wait_a(1020); a_det[3] = 1'b0;
        wait_a(1023); chk("a_timer_max", a_timer, 255);
        wait_a(1024); chk("a_timer_wrap", a_timer, 0);
        wait_a(1032); a_det[3] = 1'b1;
        wait_a(1034); chk("a_wrap_reject", a_if.out_valid, 0);
                      a_det[3] = 1'b0;
        wait_a(1036); a_det[3] = 1'b1;
        wait_a(1038); chk("a_wrap_accept_ts", a_if.out_ts, 3);
        wait_a(1040); a_det[3] = 1'b0;

        // reset with queued and pending entries, detect held through reset
        a_if.out_ready = 1'b0;
        wait_a(1120); a_det = 4'hF;
        wait_a(1124); chk("a_pre_rst_level", a_level, 3);
        a_rst = 1'b1;
        @(negedge clk);
        chk("a_mid_rst_level", a_level, 0);
        chk("a_mid_rst_valid", a_if.out_valid, 0);
        chk("a_mid_rst_ovf", a_ovf, 0);
        chk("a_mid_rst_timer", a_timer, 0);
        a_rst = 1'b0;
        wait_a(20);  chk("a_held_no_event", a_if.out_valid, 0);
                     a_det = '0;
        wait_a(30);  a_det[0] = 1'b1;
        wait_a(31);  a_det[0] = 1'b0;
        wait_a(32);  chk("a_rearm_ts", a_if.out_ts, 7);

        // fill FIFO, fill pending, then lose events; clear racing a set
        for (int p = 1; p <= 6; p++) begin
            wait_a(30 + 20 * p);
            a_det[0] = 1'b1;
            if (p == 6) a_clr = 1'b1;
            wait_a(31 + 20 * p);
            a_det[0] = 1'b0;
            a_clr = 1'b0;
            if (p == 5) begin
                chk("a_ovf_set", a_ovf[0], 1);
                chk("a_full_level", a_level, 4);
            end
            if (p == 6) chk("a_ovf_set_wins", a_ovf[0], 1);
        end
        wait_a(160); a_clr = 1'b1;
        wait_a(161); a_clr = 1'b0;
                     chk("a_ovf_cleared", a_ovf[0], 0);
                     a_if.out_ready = 1'b1;
        wait_a(175); chk("a_drained", a_level, 0);
    endtask

    task automatic run_b();
        b_rst = 1'b1; b_clr = 1'b0; b_det = '0; b_if.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        b_rst = 1'b0;
        for (int p = 1; p <= 4; p++) begin
            wait_b(2 * p);     b_det[0] = 1'b1;
            wait_b(2 * p + 1); b_det[0] = 1'b0;
        end
        wait_b(10); chk("b_full_level", b_level, 2);
                    chk("b_ovf", b_ovf, 2'b01);
                    chk("b_head_ts", b_if.out_ts, 1);
                    chk("b_head_ch", b_if.out_ch, 0);
        wait_b(12); b_if.out_ready = 1'b1;
        wait_b(13); b_if.out_ready = 1'b0;
                    chk("b_no_push_when_full", b_level, 1);
                    chk("b_head2_ts", b_if.out_ts, 2);
        wait_b(14); chk("b_pending_pushed", b_level, 2);
        wait_b(20); b_if.out_ready = 1'b1;
                    chk("b_pop_a_ts", b_if.out_ts, 2);
        wait_b(21); chk("b_pop_b_ts", b_if.out_ts, 3);
        wait_b(22); chk("b_empty", b_if.out_valid, 0);
                    b_if.out_ready = 1'b0;
        wait_b(25); b_clr = 1'b1;
        wait_b(26); b_clr = 1'b0;
                    chk("b_ovf_clr", b_ovf, 0);
    endtask

    initial begin
        fork
            run_a();
            run_b();
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
